// File: rtl/shared_pkg.sv
// shared_pkg
//   Common definitions for the FIFO write arbiter slice: the arbiter FSM
//   state type, the default sizing constants and a round-robin index helper.
package shared_pkg;

  localparam int DEF_NREQ       = 4;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_BURST_MAX  = 4;

  // Wide enough for BURST_MAX up to 15.
  localparam int BURST_CNT_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Successor of idx in round-robin order over n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
//   Combinational round-robin search. Starting at index ptr and moving
//   upward (wrapping at NREQ), the first asserted req bit wins.
// Ports
//   req     in   NREQ  request vector
//   ptr     in   PW    index with highest priority
//   winner  out  PW    first requester found from ptr (0 if none)
//   any_req out  1     at least one req bit is set
module rr_picker
  import shared_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any_req
);

  // Scan NREQ positions from ptr with wrap; the nearest requester wins.
  always_comb begin
    logic          found;
    int            idx;
    logic [PW-1:0] idx_p;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_p  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(ptr) + k >= NREQ) ? (int'(ptr) + k - NREQ) : (int'(ptr) + k);
      idx_p = PW'(idx);
      if (!found && req[idx_p]) begin
        found  = 1'b1;
        winner = idx_p;
      end else begin
        found  = found;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin burst arbiter feeding a single FIFO write port. One requester
//   owns the port for up to BURST_MAX accepted words; every burst is preceded
//   by one IDLE arbitration cycle. FIFO back-pressure stalls a burst without
//   ending it.
// Ports
//   clk, rst         in   clock, synchronous active-high reset
//   req              in   NREQ             requester i has a valid word
//   req_data         in   NREQ*FIFO_WIDTH  word i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   fifo_full        in   1                FIFO full
//   fifo_almostfull  in   1                FIFO has exactly one free slot
//   gnt              out  NREQ             combinational one-hot/zero accept
//   fifo_data_in     out  FIFO_WIDTH       registered write data
//   fifo_wr_en       out  1                registered write strobe
//   owner            out  $clog2(NREQ)     current burst owner
//   busy             out  1                FSM is in BURST
//   wr_count         out  16               accepted words, wrapping
module fifo_wr_arbiter
  import shared_pkg::*;
#(
  parameter int  NREQ       = DEF_NREQ,
  parameter int  FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int  BURST_MAX  = DEF_BURST_MAX,
  localparam int PW         = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*FIFO_WIDTH-1:0] req_data,
  input  logic                       fifo_full,
  input  logic                       fifo_almostfull,
  output logic [NREQ-1:0]            gnt,
  output logic [FIFO_WIDTH-1:0]      fifo_data_in,
  output logic                       fifo_wr_en,
  output logic [PW-1:0]              owner,
  output logic                       busy,
  output logic [15:0]                wr_count
);

  arb_state_e             state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]  data_q, data_d;
  logic                   busy_q, busy_d;
  logic [15:0]            wr_count_q, wr_count_d;

  logic [PW-1:0]          pick_winner_s;
  logic                   pick_any_s;
  logic                   space_s;
  logic                   owner_req_s;
  logic                   grant_s;
  logic                   last_grant_s;
  logic [PW-1:0]          next_owner_s;
  logic [FIFO_WIDTH-1:0]  words_s [NREQ];
  logic [FIFO_WIDTH-1:0]  owner_word_s;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_winner_s),
    .any_req (pick_any_s)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign words_s[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
  end

  assign owner_word_s = words_s[owner_q];
  assign owner_req_s  = req[owner_q];

  // A write already in flight consumes the last free slot, so almost-full
  // must be treated as full while fifo_wr_en is high.
  assign space_s      = !fifo_full && !(wr_en_q && fifo_almostfull);
  assign grant_s      = (state_q == ST_BURST) && owner_req_s && space_s;
  assign last_grant_s = (burst_cnt_q == BURST_CNT_W'(BURST_MAX - 1));
  assign next_owner_s = PW'(rr_next(int'(owner_q), NREQ));

  // FSM state, ownership, burst counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      wr_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Next-state logic: arbitration in IDLE, burst bookkeeping in BURST.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d     = ST_BURST;
          owner_d     = pick_winner_s;
          burst_cnt_d = '0;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (!owner_req_s) begin
          state_d = ST_IDLE;
          ptr_d   = next_owner_s;
        end else if (grant_s) begin
          burst_cnt_d = burst_cnt_q + {{(BURST_CNT_W-1){1'b0}}, 1'b1};
          if (last_grant_s) begin
            state_d = ST_IDLE;
            ptr_d   = next_owner_s;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          // FIFO stall: ownership and count are held.
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: combinational grant and next values of registered outputs.
  always_comb begin
    gnt        = '0;
    wr_en_d    = grant_s;
    data_d     = data_q;
    wr_count_d = wr_count_q;
    busy_d     = (state_d == ST_BURST);
    if (grant_s) begin
      gnt[owner_q] = 1'b1;
      data_d       = owner_word_s;
      wr_count_d   = wr_count_q + 16'd1;
    end else begin
      gnt          = '0;
    end
  end

  assign fifo_data_in = data_q;
  assign fifo_wr_en   = wr_en_q;
  assign owner        = owner_q;
  assign busy         = busy_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int BM   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic            fifo_full = 1'b0;
  logic            fifo_almostfull = 1'b0;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    fifo_data_in;
  logic            fifo_wr_en;
  logic [1:0]      owner;
  logic            busy;
  logic [15:0]     wr_count;

  int checks = 0;
  int errors = 0;

  localparam logic [NREQ*W-1:0] WORDS = {16'hC0D3, 16'hC0D2, 16'hC0D1, 16'hC0D0};

  fifo_wr_arbiter #(.NREQ(NREQ), .FIFO_WIDTH(W), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
    .gnt(gnt), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .owner(owner), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic        m_busy = 1'b0;
  int          m_owner = 0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic        m_wr = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [15:0] m_total = 16'd0;

  function automatic logic [NREQ-1:0] model_gnt();
    logic room;
    room = !fifo_full && !(m_wr && fifo_almostfull);
    if (m_busy && req[m_owner] && room) return NREQ'(1) << m_owner;
    return '0;
  endfunction

  function automatic int first_from(input int p);
    for (int k = 0; k < NREQ; k++) if (req[(p + k) % NREQ]) return (p + k) % NREQ;
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_owner <= 0; m_ptr <= 0; m_cnt <= 0;
      m_wr <= 1'b0; m_data <= '0; m_total <= 16'd0;
    end else if (!m_busy) begin
      m_wr <= 1'b0;
      if (req != '0) begin
        m_busy <= 1'b1; m_owner <= first_from(m_ptr); m_cnt <= 0;
      end
    end else begin
      m_wr <= (model_gnt() != '0);
      if (model_gnt() != '0) begin
        m_data  <= req_data[m_owner*W +: W];
        m_total <= m_total + 16'd1;
        m_cnt   <= m_cnt + 1;
      end
      if (!req[m_owner] || (model_gnt() != '0 && m_cnt + 1 == BM)) begin
        m_busy <= 1'b0;
        m_ptr  <= (m_owner + 1) % NREQ;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; fifo_full = 1'b0; fifo_almostfull = 1'b0; req_data = WORDS;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    req = 4'hF; #1;
    if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end checks++;
    if (fifo_data_in !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", fifo_data_in); end checks++;
    if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end checks++;
    if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end checks++;
  endtask

  task automatic test_burst_limit();
    logic [3:0] eg;
    logic       prev;
    apply_reset();
    prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); rst = 1'b0; req = 4'b0001; #1;
      eg = (c % 5 == 0) ? 4'b0000 : 4'b0001;
      if (gnt !== eg) begin errors++; $display("FAIL burst_gnt c=%0d got %b want %b", c, gnt, eg); end checks++;
      if (fifo_wr_en !== prev) begin errors++; $display("FAIL burst_wr_en c=%0d got %b want %b", c, fifo_wr_en, prev); end checks++;
      prev = (eg != 4'b0000);
    end
    @(negedge clk); #1;
    if (wr_count !== 16'd8) begin errors++; $display("FAIL burst_wr_count got %0d want 8", wr_count); end checks++;
    if (fifo_data_in !== 16'hC0D0) begin errors++; $display("FAIL burst_data got %h want c0d0", fifo_data_in); end checks++;
  endtask

  task automatic test_rotation();
    logic [3:0] eg;
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk); rst = 1'b0; req = 4'b1111; #1;
      eg = (c % 5 == 0) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
      if (gnt !== eg) begin errors++; $display("FAIL rot_gnt c=%0d got %b want %b", c, gnt, eg); end checks++;
      if (c % 5 != 0) begin
        if (owner !== 2'((c / 5) % 4)) begin errors++; $display("FAIL rot_owner c=%0d got %0d want %0d", c, owner, (c / 5) % 4); end checks++;
      end
    end
  endtask

  task automatic test_full_stall();
    logic [3:0] ge [9];
    logic       prev;
    ge = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};
    apply_reset();
    prev = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); rst = 1'b0; req = 4'b0100; fifo_full = (c >= 3 && c <= 5); #1;
      if (gnt !== ge[c]) begin errors++; $display("FAIL stall_gnt c=%0d got %b want %b", c, gnt, ge[c]); end checks++;
      if (fifo_wr_en !== prev) begin errors++; $display("FAIL stall_wr_en c=%0d got %b want %b", c, fifo_wr_en, prev); end checks++;
      if (busy !== (c >= 1 && c <= 7)) begin errors++; $display("FAIL stall_busy c=%0d got %b want %b", c, busy, (c >= 1 && c <= 7)); end checks++;
      if (c >= 1 && owner !== 2'd2) begin errors++; $display("FAIL stall_owner c=%0d got %0d want 2", c, owner); end checks++;
      prev = (ge[c] != 4'h0);
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_almost_full();
    logic [3:0] ge [7];
    logic       fe [7];
    logic       ae [7];
    logic       prev;
    ge = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
    fe = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ae = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    prev = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); rst = 1'b0; req = 4'b0001; fifo_full = fe[c]; fifo_almostfull = ae[c]; #1;
      if (gnt !== ge[c]) begin errors++; $display("FAIL afull_gnt c=%0d got %b want %b", c, gnt, ge[c]); end checks++;
      if (fifo_wr_en !== prev) begin errors++; $display("FAIL afull_wr_en c=%0d got %b want %b", c, fifo_wr_en, prev); end checks++;
      prev = (ge[c] != 4'h0);
    end
    if (fifo_data_in !== 16'hC0D0) begin errors++; $display("FAIL afull_data got %h want c0d0", fifo_data_in); end checks++;
    fifo_full = 1'b0; fifo_almostfull = 1'b0;
  endtask

  task automatic test_early_drop();
    logic [3:0] re [6];
    logic [3:0] ge [6];
    logic       be [6];
    re = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0011, 4'b0011};
    ge = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h1};
    be = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); rst = 1'b0; req = re[c]; #1;
      if (gnt !== ge[c]) begin errors++; $display("FAIL drop_gnt c=%0d got %b want %b", c, gnt, ge[c]); end checks++;
      if (busy !== be[c]) begin errors++; $display("FAIL drop_busy c=%0d got %b want %b", c, busy, be[c]); end checks++;
    end
    if (owner !== 2'd0) begin errors++; $display("FAIL drop_owner got %0d want 0", owner); end checks++;
    if (wr_count !== 16'd2) begin errors++; $display("FAIL drop_wr_count got %0d want 2", wr_count); end checks++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); rst = 1'b0; req = 4'b1000; #1;
    end
    if (owner !== 2'd3 || gnt !== 4'b1000) begin errors++; $display("FAIL midrst_pre got owner %0d gnt %b want 3 1000", owner, gnt); end checks++;
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; req = 4'b1111; #1;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en got %b want 0", fifo_wr_en); end checks++;
    if (wr_count !== 16'd0) begin errors++; $display("FAIL midrst_wr_count got %0d want 0", wr_count); end checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt got %b want 0000", gnt); end checks++;
    @(negedge clk); #1;
    if (owner !== 2'd0 || gnt !== 4'b0001) begin errors++; $display("FAIL midrst_ptr got owner %0d gnt %b want 0 0001", owner, gnt); end checks++;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic        prev_full;
    apply_reset();
    prev_full = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      r = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      req = r[3:0] | r[7:4];
      fifo_full = ($urandom_range(0, 4) == 0);
      fifo_almostfull = ($urandom_range(0, 3) == 0);
      req_data = {$urandom, $urandom};
      #1;
      if (gnt !== model_gnt()) begin errors++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, gnt, model_gnt()); end checks++;
      if (fifo_wr_en !== m_wr) begin errors++; $display("FAIL rnd_wr_en c=%0d got %b want %b", c, fifo_wr_en, m_wr); end checks++;
      if (fifo_data_in !== m_data) begin errors++; $display("FAIL rnd_data c=%0d got %h want %h", c, fifo_data_in, m_data); end checks++;
      if (wr_count !== m_total) begin errors++; $display("FAIL rnd_wr_count c=%0d got %0d want %0d", c, wr_count, m_total); end checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, m_busy); end checks++;
      if (owner !== 2'(m_owner)) begin errors++; $display("FAIL rnd_owner c=%0d got %0d want %0d", c, owner, m_owner); end checks++;
      if (fifo_wr_en && prev_full) begin errors++; $display("FAIL rnd_write_when_full c=%0d got wr_en 1 want 0", c); end checks++;
      prev_full = fifo_full;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_burst_limit();
    test_rotation();
    test_full_stall();
    test_almost_full();
    test_early_drop();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
